// File: rtl/exec_issue_scheduler_pkg.sv
// Shared micro-op types for the issue queue and scheduler.
// Provides the reservation-station cell and the load/store classifier.
package exec_issue_scheduler_pkg;

  typedef enum logic [3:0] {
    OPT_ALU,
    OPT_MUL,
    OPT_BR,
    OPT_LOAD,
    OPT_STORE,
    OPT_CSR
  } optype_t;

  typedef struct packed {
    optype_t    optype;
    logic [3:0] func;
  } uop_t;

  typedef struct packed {
    uop_t        op;
    logic [4:0]  rd;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  rob_tag;
  } res_st_cell_t;

  function automatic logic is_ldst(input optype_t optype);
    return optype inside {OPT_LOAD, OPT_STORE};
  endfunction

endpackage

// File: rtl/exec_issue_scheduler_rr_picker.sv
// Round-robin picker: first set bit of elig scanning up from ptr,
// wrapping modulo N.
module rr_picker #(
  parameter  int N  = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  grant_onehot,
  output logic [PW-1:0] idx
);

  int j;

  always_comb begin
    any          = 1'b0;
    idx          = '0;
    grant_onehot = '0;
    j            = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && elig[j]) begin
        any             = 1'b1;
        idx             = PW'(j);
        grant_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_issue_scheduler.sv
// Dual-port issue scheduler: one ALU op and one load/store op per
// cycle from the reservation station into registered issue slots.
module exec_issue_scheduler
  import exec_issue_scheduler_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_ENTRIES-1:0] entry_valid_in,
  input  logic [NUM_ENTRIES-1:0] entry_ready_in,
  input  res_st_cell_t           entries_in [NUM_ENTRIES],
  input  logic                   alu_stall_in,
  input  logic                   ldst_stall_in,
  output logic [NUM_ENTRIES-1:0] alu_grant_out,
  output logic [NUM_ENTRIES-1:0] ldst_grant_out,
  output res_st_cell_t           op1_out,
  output logic                   op1_valid_out,
  output res_st_cell_t           op2_out,
  output logic                   op2_valid_out
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] alu_elig, ldst_elig;
  logic [NUM_ENTRIES-1:0] alu_oh, ldst_oh;
  logic                   alu_any, ldst_any;
  logic                   alu_accept, ldst_accept;
  logic                   alu_go, ldst_go;
  logic [PTR_W-1:0]       alu_idx, ldst_idx;
  logic [PTR_W-1:0]       alu_rr_ptr, ldst_rr_ptr;

  always_comb begin
    alu_elig  = '0;
    ldst_elig = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ldst_elig[i] = entry_valid_in[i] & entry_ready_in[i] &
                     is_ldst(entries_in[i].op.optype);
      alu_elig[i]  = entry_valid_in[i] & entry_ready_in[i] &
                     !is_ldst(entries_in[i].op.optype);
    end
  end

  rr_picker #(.N(NUM_ENTRIES)) u_alu_pick (
    .elig         (alu_elig),
    .ptr          (alu_rr_ptr),
    .any          (alu_any),
    .grant_onehot (alu_oh),
    .idx          (alu_idx)
  );

  rr_picker #(.N(NUM_ENTRIES)) u_ldst_pick (
    .elig         (ldst_elig),
    .ptr          (ldst_rr_ptr),
    .any          (ldst_any),
    .grant_onehot (ldst_oh),
    .idx          (ldst_idx)
  );

  assign alu_accept  = !op1_valid_out || !alu_stall_in;
  assign ldst_accept = !op2_valid_out || !ldst_stall_in;
  assign alu_go      = alu_any & alu_accept & !flush & !rst;
  assign ldst_go     = ldst_any & ldst_accept & !flush & !rst;

  assign alu_grant_out  = alu_go  ? alu_oh  : '0;
  assign ldst_grant_out = ldst_go ? ldst_oh : '0;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] i
  );
    return (i == PTR_W'(NUM_ENTRIES - 1)) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_out       <= '0;
      op2_out       <= '0;
      op1_valid_out <= 1'b0;
      op2_valid_out <= 1'b0;
      alu_rr_ptr    <= '0;
      ldst_rr_ptr   <= '0;
    end else if (flush) begin
      op1_valid_out <= 1'b0;
      op2_valid_out <= 1'b0;
    end else begin
      if (alu_go) begin
        op1_out       <= entries_in[alu_idx];
        op1_valid_out <= 1'b1;
        alu_rr_ptr    <= wrap_inc(alu_idx);
      end else if (alu_accept) begin
        op1_valid_out <= 1'b0;
      end
      if (ldst_go) begin
        op2_out       <= entries_in[ldst_idx];
        op2_valid_out <= 1'b1;
        ldst_rr_ptr   <= wrap_inc(ldst_idx);
      end else if (ldst_accept) begin
        op2_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_issue_scheduler.sv
// Bench for exec_issue_scheduler: directed table, fairness sequence
// and random traffic against a queue-level reference model.
module tb_exec_issue_scheduler;
  import exec_issue_scheduler_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic [N-1:0] ev, er, lm;
  res_st_cell_t ents [N];
  logic         as, ls;
  logic [N-1:0] alu_grant, ldst_grant;
  res_st_cell_t op1, op2;
  logic         op1_v, op2_v;

  exec_issue_scheduler #(.NUM_ENTRIES(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .entry_valid_in (ev),
    .entry_ready_in (er),
    .entries_in     (ents),
    .alu_stall_in   (as),
    .ldst_stall_in  (ls),
    .alu_grant_out  (alu_grant),
    .ldst_grant_out (ldst_grant),
    .op1_out        (op1),
    .op1_valid_out  (op1_v),
    .op2_out        (op2),
    .op2_valid_out  (op2_v)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         m_v1 = 0, m_v2 = 0;
  res_st_cell_t m_c1 = '0, m_c2 = '0;
  int           m_p1 = 0, m_p2 = 0;
  logic [N-1:0] prev_ag = '0, prev_lg = '0;
  logic [N-1:0] got_ag, got_lg;

  typedef struct {
    logic [N-1:0] v, r, l;
    logic         as, ls, fl;
    logic [N-1:0] eag, elg;
  } vec_t;

  vec_t    tbl [10];
  optype_t alu_ops [4] = '{OPT_ALU, OPT_MUL, OPT_BR, OPT_CSR};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] e, input int p);
    for (int k = 0; k < N; k++)
      if (e[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic fill();
    for (int i = 0; i < N; i++) begin
      ents[i].op.optype = lm[i] ?
        ($urandom_range(0, 1) ? OPT_LOAD : OPT_STORE) :
        alu_ops[$urandom_range(0, 3)];
      ents[i].op.func = 4'($urandom());
      ents[i].rd      = 5'($urandom());
      ents[i].src1    = $urandom();
      ents[i].src2    = $urandom();
      ents[i].rob_tag = 6'($urandom());
    end
  endtask

  // Inputs are already applied; checks grants, clocks, checks slots.
  task automatic cycle();
    logic [N-1:0] ae, le, xa, xl;
    logic         a_acc, l_acc, r;
    int           ai, li;
    ae    = ev & er & ~lm;
    le    = ev & er & lm;
    a_acc = !m_v1 || !as;
    l_acc = !m_v2 || !ls;
    ai    = pick(ae, m_p1);
    li    = pick(le, m_p2);
    r     = rst;
    xa    = '0;
    xl    = '0;
    if (ai >= 0 && a_acc && !flush && !rst) xa[ai] = 1'b1;
    if (li >= 0 && l_acc && !flush && !rst) xl[li] = 1'b1;
    #1;
    got_ag = alu_grant;
    got_lg = ldst_grant;
    chk("alu_grant", got_ag, xa);
    chk("ldst_grant", got_lg, xl);
    if (rst) begin
      m_v1 = 0; m_v2 = 0; m_c1 = '0; m_c2 = '0; m_p1 = 0; m_p2 = 0;
    end else if (flush) begin
      m_v1 = 0; m_v2 = 0;
    end else begin
      if (xa != '0) begin
        m_c1 = ents[ai]; m_v1 = 1; m_p1 = (ai + 1) % N;
      end else if (a_acc) m_v1 = 0;
      if (xl != '0) begin
        m_c2 = ents[li]; m_v2 = 1; m_p2 = (li + 1) % N;
      end else if (l_acc) m_v2 = 0;
    end
    prev_ag = xa;
    prev_lg = xl;
    @(posedge clk);
    #1;
    chk("op1_valid", op1_v, m_v1);
    chk("op2_valid", op2_v, m_v2);
    chk("alu_ptr", int'(dut.alu_rr_ptr), m_p1);
    chk("ldst_ptr", int'(dut.ldst_rr_ptr), m_p2);
    if (m_v1 || r) chk("op1_out", op1, m_c1);
    if (m_v2 || r) chk("op2_out", op2, m_c2);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; ev = '1; er = '1; lm = 8'h0F; as = 0; ls = 0;
    fill();
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    logic [N-1:0] fair_exp [4];
    rst = 1; flush = 0; ev = '0; er = '0; lm = '0; as = 0; ls = 0;
    fill();
    @(posedge clk);
    #1;

    // Reset and idle
    do_reset();
    ev = '0; er = '0;
    cycle();
    chk("idle_op1_out", op1, '0);

    // Directed table, hand-derived grants from the reset state
    tbl[0] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00};
    tbl[1] = '{8'h08, 8'h08, 8'h00, 0, 0, 0, 8'h08, 8'h00};
    tbl[2] = '{8'h44, 8'h44, 8'h40, 0, 0, 0, 8'h04, 8'h40};
    tbl[3] = '{8'h02, 8'h02, 8'h00, 1, 0, 0, 8'h00, 8'h00};
    tbl[4] = '{8'h02, 8'h02, 8'h00, 1, 0, 0, 8'h00, 8'h00};
    tbl[5] = '{8'h02, 8'h02, 8'h00, 1, 0, 0, 8'h00, 8'h00};
    tbl[6] = '{8'h02, 8'h02, 8'h00, 0, 0, 0, 8'h02, 8'h00};
    tbl[7] = '{8'h20, 8'h20, 8'h20, 0, 0, 0, 8'h00, 8'h20};
    tbl[8] = '{8'h09, 8'h09, 8'h08, 0, 1, 1, 8'h00, 8'h00};
    tbl[9] = '{8'hA1, 8'hA1, 8'h00, 0, 0, 0, 8'h20, 8'h00};
    do_reset();
    for (int t = 0; t < 10; t++) begin
      ev = tbl[t].v; er = tbl[t].r; lm = tbl[t].l;
      as = tbl[t].as; ls = tbl[t].ls; flush = tbl[t].fl;
      fill();
      cycle();
      chk($sformatf("tbl%0d_alu", t), got_ag, tbl[t].eag);
      chk($sformatf("tbl%0d_ldst", t), got_lg, tbl[t].elg);
      if (t == 1) chk("single_alu_ptr", int'(dut.alu_rr_ptr), 4);
      if (t == 8) begin
        chk("flush_op2_valid", op2_v, 1'b0);
        chk("flush_alu_ptr", int'(dut.alu_rr_ptr), 2);
        chk("flush_ldst_ptr", int'(dut.ldst_rr_ptr), 6);
      end
    end
    flush = 0;

    // Fairness: 0,5,7 eligible, granted entry absent for one cycle
    fair_exp = '{8'h01, 8'h20, 8'h80, 8'h01};
    do_reset();
    prev_ag = '0;
    for (int t = 0; t < 4; t++) begin
      ev = 8'hA1 & ~prev_ag; er = '1; lm = '0; as = 0; ls = 0;
      fill();
      cycle();
      chk($sformatf("fair%0d", t), got_ag, fair_exp[t]);
      if (t == 2) chk("fair_wrap_ptr", int'(dut.alu_rr_ptr), 0);
    end

    // Random traffic honouring the one-cycle RS free contract
    do_reset();
    for (int t = 0; t < 400; t++) begin
      ev    = N'($urandom()) & ~(prev_ag | prev_lg);
      er    = N'($urandom() | $urandom());
      lm    = N'($urandom());
      as    = ($urandom_range(0, 3) == 0);
      ls    = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      fill();
      cycle();
    end
    rst = 0;
    flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
